// File: rtl/e9bit_serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB-first, one full-subtractor slice per clock.
// Optional floor clamp of diff to zero on borrow-out: define E9BIT_SERIAL_SUB_SAT_EN.
module e9bit_serial_sub #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_nxt;

    assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Result is published from the shift-in value so diff never shows a partial word.
                    state_d = DONE;
                    bout_d  = br_nxt;
`ifdef E9BIT_SERIAL_SUB_SAT_EN
                    diff_d  = br_nxt ? '0 : res_d;
`else
                    diff_d  = res_d;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_e9bit_serial_sub.sv
// Self-checking bench for e9bit_serial_sub: directed cases plus a randomized back-to-back sweep
// against an arithmetic reference model.
module tb_e9bit_serial_sub;

    localparam int unsigned W = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_diff = '0;

    always #5 clk = ~clk;

    e9bit_serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
    );

    function automatic logic model_bout(input int unsigned x, input int unsigned y, input int unsigned c);
        return (x < y + c);
    endfunction

    function automatic logic [W-1:0] model_diff(input int unsigned x, input int unsigned y, input int unsigned c);
        logic [31:0] t;
        t = x - y - c;
`ifdef E9BIT_SERIAL_SUB_SAT_EN
        if (x < y + c) t = '0;
`endif
        return t[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int unsigned x, input int unsigned y, input int unsigned c);
        logic [31:0] xv, yv, cv;
        xv = x; yv = y; cv = c;
        a = xv[W-1:0];
        b = yv[W-1:0];
        bin = cv[0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the accepting edge; checks latency, busy length, hold, result, return to idle.
    task automatic wait_done(input int unsigned x, input int unsigned y, input int unsigned c,
                             input bit scramble);
        int n = 0;
        int nbusy = 0;
        bit held = 1'b1;
        if (busy) nbusy++;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!done && n < 20) begin
            if (diff !== last_diff) held = 1'b0;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
            end
            tick();
            n++;
            if (busy) nbusy++;
        end
        chk("done_latency", 32'(n), 32'(W));
        chk("busy_cycles", 32'(nbusy), 32'(W + 1));
        chk("diff_held", 32'(held), 32'd1);
        chk("diff", 32'(diff), 32'(model_diff(x, y, c)));
        chk("bout", 32'(bout), 32'(model_bout(x, y, c)));
        last_diff = model_diff(x, y, c);
        tick();
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        int unsigned x, y, c;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        start_op(300, 45, 0);  wait_done(300, 45, 0, 0);
        start_op(45, 300, 0);  wait_done(45, 300, 0, 0);
        start_op(0, 0, 1);     wait_done(0, 0, 1, 0);
        start_op(511, 511, 0); wait_done(511, 511, 0, 0);

        // Starts during SHIFT and DONE are ignored.
        start_op(100, 1, 0);
        chk("busy_ign", 32'(busy), 32'd1);
        ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done) begin
                ndone++;
                chk("ign_diff", 32'(diff), 32'd99);
                chk("ign_bout", 32'(bout), 32'd0);
            end
            start = (i == 3 || i == 9);
            if (start) begin
                a = 7; b = 7; bin = 0;
            end
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_idle", 32'(busy), 32'd0);
        last_diff = 99;
        start_op(5, 2, 0); wait_done(5, 2, 0, 0);

        // Asynchronous reset mid-operation, then start held across release.
        start_op(200, 50, 0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        a = 10; b = 3; bin = 0; start = 1'b1;
        tick();
        chk("in_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        last_diff = '0;
        wait_done(10, 3, 0, 0);

        // Random sweep with start held high: one op every W+2 cycles.
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom_range(0, 511);
            y = $urandom_range(0, 511);
            c = $urandom_range(0, 1);
            a = W'(x); b = W'(y); bin = 1'(c);
            tick();
            wait_done(x, y, c, 1);
        end
        start = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e9bit_serial_sub.md
Name: e9bit_serial_sub

Overview:
- Bit-serial 9-bit subtractor: diff = A - B - Bin, computed LSB-first, one bit per clock, using a single full-subtractor slice and a borrow flop.
- This is the inverse-direction companion of the 9-bit ripple-carry full-adder chain. It serves as the neuron-potential decrement (leak/inhibition) path.
- Trades the 9-stage ripple for a 9-cycle sequential operation with a start/done handshake.

Parameters:
- WIDTH, 9, operand/result width in bits (counter sized as clog2(WIDTH+1)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse/level; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; diff/bout valid
- diff  output  WIDTH  result, held until next accepted start
- bout  output  1  borrow-out (1 when a < b + bin), held with diff

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, diff=0, bout=0, internal operand regs/counter/borrow cleared. Asynchronous assertion takes effect immediately, including mid-operation; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on a clock edge with start=1:
  - load a_r<=a, b_r<=b, br<=bin, cnt<=0
  - state->SHIFT
  - otherwise stay in IDLE.
- SHIFT, each edge:
  - d = a_r[0]^b_r[0]^br
  - br <= (~a_r[0] & b_r[0]) | (~(a_r[0]^b_r[0]) & br)
  - a_r, b_r shift right by 1
  - result shift register gets d in the MSB and shifts right
  - cnt++
  - when cnt==WIDTH-1 on this edge: state->DONE, diff<=final result, bout<=final borrow.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: start accepted at edge k; done high between edges k+WIDTH and k+WIDTH+1; busy high for WIDTH+1 cycles.
- start while busy (SHIFT or DONE): ignored, no queuing. Back-to-back throughput is one op per WIDTH+2 cycles.
- diff and bout change only when entering DONE (and at reset). Partial results are never visible on diff.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout = borrow out of the MSB.
- Inputs a/b/bin changing after capture have no effect on the ongoing op.
- Deassertion of rst_n with start already high: the start is accepted at the first clock edge after release.

Optional Feature:
- Macro: E9BIT_SERIAL_SUB_SAT_EN.
- Defined: on entry to DONE, if final borrow=1, diff<=0 (floor clamp for membrane potential); bout still reports 1.
- Undefined: diff is the wrapped modulo-2^WIDTH result. No clamp logic is synthesised.

Test Plan:
- a=300, b=45, bin=0, start pulse -> done exactly 9 cycles after the start edge (busy 10 cycles); diff=255, bout=0.
- a=45, b=300, bin=0 -> diff=257, bout=1. With E9BIT_SERIAL_SUB_SAT_EN defined: diff=0, bout=1.
- a=0, b=0, bin=1 -> diff=511, bout=1. Then a=511, b=511, bin=0 -> diff=0, bout=0; diff holds 511 until the second DONE.
- Start a=100, b=1; pulse start again at cycles 3 and 9 with a=7, b=7 -> those starts are ignored; a single done with diff=99. A start in the IDLE cycle after done is accepted.
- Start a=200, b=50; assert rst_n=0 at cycle 4 -> busy/done/diff/bout go to 0 immediately. After release, a=10, b=3 -> diff=7, bout=0.
- Random sweep of 1000 ops (a, b, bin random), compared against the (a-b-bin) mod 512 model, with start held high continuously -> exactly one op per 11 cycles, all results match.
